// File: rtl/pmem_loader_pkg.sv
// ---------------------------------------------------------------------------
// pmem_loader_pkg
// Shared definitions for the program-memory loader: the byte and instruction
// widths and the loader state encoding.
//
// Optional feature macro: PMEM_LOADER_CHECKSUM_EN
//   When defined, the CHECK state exists and the loader expects one trailing
//   checksum byte after the program words.
// ---------------------------------------------------------------------------
package pmem_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int INSTR_W = 12;

    // Encodings are pinned so the state values stay the same whether or not
    // the checksum state is compiled in.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RX_LO = 3'd1,
        RX_HI = 3'd2,
        WRITE = 3'd3,
`ifdef PMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd4,
`endif
        DONE  = 3'd5
    } pl_state_e;

    // True in the states where a new load may be launched by start.
    function automatic logic canStart(input pl_state_e s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/pmem_loader_cksum.sv
// ---------------------------------------------------------------------------
// pmem_loader_cksum
// Running modulo-256 byte accumulator used to verify a program image.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset, clears the sum
//   i_clear    synchronous clear (start of a new load)
//   i_add      add i_data into the sum this cycle
//   i_data     byte to accumulate
//   i_ref      reference byte to compare against the current sum
//   o_mismatch 1 when i_ref differs from the current sum
// ---------------------------------------------------------------------------
module pmem_loader_cksum
    import pmem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_add,
    input  logic [BYTE_W-1:0] i_data,
    input  logic [BYTE_W-1:0] i_ref,
    output logic              o_mismatch
);

    logic [BYTE_W-1:0] r_sum;

    // Clear has priority so a start on the same cycle as a stray add
    // still begins the new image from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_mismatch = (i_ref != r_sum);

endmodule

// File: rtl/pmem_loader.sv
// ---------------------------------------------------------------------------
// pmem_loader
// Receives a byte stream (low byte then high nibble per word) and writes
// DEPTH 12-bit instructions into program memory through LE/LA/LI.
//
// Optional feature macro: PMEM_LOADER_CHECKSUM_EN
//   Adds a CHECK state that accepts one extra byte and flags err if it does
//   not equal the modulo-256 sum of all 2*DEPTH data bytes.
//
// Parameters:
//   DEPTH      program words per load
//   AW         load-address width
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   start      one-cycle load request (ignored while busy)
//   in_valid   byte-stream valid
//   in_data    byte-stream data
//   in_ready   loader accepts a byte this cycle
//   LE         program-memory load enable, one cycle per word
//   LA         program-memory load address
//   LI         program-memory load instruction
//   load_done  all words written, held until next start or reset
//   busy       load in progress
//   err        sticky format/checksum error for the current load
// ---------------------------------------------------------------------------
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    output logic               LE,
    output logic [AW-1:0]      LA,
    output logic [INSTR_W-1:0] LI,
    output logic               load_done,
    output logic               busy,
    output logic               err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    pl_state_e          r_state;
    logic [AW-1:0]      r_la;
    logic [INSTR_W-1:0] r_li;
    logic               r_le;
    logic               r_inReady;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_xfer;

    assign w_xfer = in_valid && r_inReady;

`ifdef PMEM_LOADER_CHECKSUM_EN
    logic w_ckClear;
    logic w_ckAdd;
    logic w_ckBad;

    // Only the program bytes are summed; the checksum byte itself is compared.
    assign w_ckClear = canStart(r_state) && start;
    assign w_ckAdd   = w_xfer && ((r_state == RX_LO) || (r_state == RX_HI));

    pmem_loader_cksum u_cksum (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_ckClear),
        .i_add      (w_ckAdd),
        .i_data     (in_data),
        .i_ref      (in_data),
        .o_mismatch (w_ckBad)
    );
`endif

    // Single FSM; every output flag is registered and updated on the
    // transition that enters the state it belongs to, so outputs never
    // depend combinationally on inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_la      <= '0;
            r_li      <= '0;
            r_le      <= 1'b0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= RX_LO;
                        r_la      <= '0;
                        r_err     <= 1'b0;
                        r_done    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_inReady <= 1'b1;
                    end
                end
                RX_LO: begin
                    if (w_xfer) begin
                        r_li[7:0] <= in_data;
                        r_state   <= RX_HI;
                    end
                end
                RX_HI: begin
                    // A non-zero upper nibble is a format error, but the
                    // word is still written so the address sequence holds.
                    if (w_xfer) begin
                        r_li[11:8] <= in_data[3:0];
                        if (in_data[7:4] != 4'h0) begin
                            r_err <= 1'b1;
                        end
                        r_state   <= WRITE;
                        r_inReady <= 1'b0;
                        r_le      <= 1'b1;
                    end
                end
                WRITE: begin
                    r_le <= 1'b0;
                    // Stop at the last address rather than incrementing,
                    // so LA never leaves 0..DEPTH-1.
                    if (r_la == LAST_ADDR) begin
`ifdef PMEM_LOADER_CHECKSUM_EN
                        r_state   <= CHECK;
                        r_inReady <= 1'b1;
`else
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
`endif
                    end else begin
                        r_la      <= r_la + 1'b1;
                        r_state   <= RX_LO;
                        r_inReady <= 1'b1;
                    end
                end
`ifdef PMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_xfer) begin
                        if (w_ckBad) begin
                            r_err <= 1'b1;
                        end
                        r_state   <= DONE;
                        r_inReady <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state   <= IDLE;
                    r_le      <= 1'b0;
                    r_inReady <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign LE        = r_le;
    assign LA        = r_la;
    assign LI        = r_li;
    assign load_done = r_done;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_pmem_loader.sv
// ---------------------------------------------------------------------------
// tb_pmem_loader
// Self-checking bench for pmem_loader. Each load computes the words it
// expects from the byte image and pushes them into a scoreboard queue; a
// separate monitor pops and compares on every LE pulse.
// Honours PMEM_LOADER_CHECKSUM_EN by appending a checksum byte to each load.
// ---------------------------------------------------------------------------
module tb_pmem_loader;

    localparam int DEPTH  = 10;
    localparam int AW     = 8;
    localparam int BUDGET = 400;
`ifdef PMEM_LOADER_CHECKSUM_EN
    localparam int CKSUM  = 1;
`else
    localparam int CKSUM  = 0;
`endif
    localparam int NBYTES = 2 * DEPTH + CKSUM;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          LE;
    logic [AW-1:0] LA;
    logic [11:0]   LI;
    logic          load_done;
    logic          busy;
    logic          err;

    typedef struct packed {
        logic [AW-1:0] la;
        logic [11:0]   li;
    } word_t;

    word_t      expQ[$];
    logic [7:0] stream[2*DEPTH];
    int         vectors    = 0;
    int         miscompares = 0;
    int         leCount    = 0;

    pmem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .LE        (LE),
        .LA        (LA),
        .LI        (LI),
        .load_done (load_done),
        .busy      (busy),
        .err       (err)
    );

    // 10 ns clock; the bench drives and samples on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every LE pulse must match the next expected word.
    always @(negedge clk) begin : monitor
        word_t w;
        if (rst && LE) begin
            leCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_LE", {24'h0, LA}, 32'hFFFF_FFFF);
            end else begin
                w = expQ.pop_front();
                checkOutput("LE_addr", {24'h0, LA}, {24'h0, w.la});
                checkOutput("LE_instr", {20'h0, LI}, {20'h0, w.li});
            end
        end
    end

    // Counting pattern 0x01,0x0A,0x02,0x0B,... giving words 0xA01, 0xB02, ...
    task automatic fillPattern();
        for (int w = 0; w < DEPTH; w++) begin
            stream[2*w]   = 8'(w + 1);
            stream[2*w+1] = 8'(8'h0A + w);
        end
    endtask

    // Random image; roughly a quarter of high bytes carry a bad upper nibble.
    task automatic fillRandom();
        for (int w = 0; w < DEPTH; w++) begin
            stream[2*w] = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                stream[2*w+1] = 8'($urandom);
            else
                stream[2*w+1] = {4'h0, 4'($urandom)};
        end
    endtask

    // Runs one load. gapMode: 0 continuous, 1 valid one cycle in three,
    // 2 random. injectStart pulses start during a high-byte phase.
    // abortAfter>0 asserts reset once that many words have been written.
    task automatic applyStimulus(input int gapMode, input bit injectStart, input int abortAfter,
                                 input bit badSum, input bit checkCycles);
        int         cyc;
        int         idx;
        int         gapCnt;
        int         leAtReset;
        bit         fire;
        bit         injected;
        bit         expErr;
        logic [7:0] sum;
        logic [7:0] checkByte;
        word_t      e;

        // Reference model: words, error flag and checksum from the image.
        sum    = 8'h00;
        expErr = 1'b0;
        for (int w = 0; w < DEPTH; w++) begin
            e.la = AW'(w);
            e.li = {stream[2*w+1][3:0], stream[2*w]};
            expQ.push_back(e);
            if (stream[2*w+1][7:4] != 4'h0) expErr = 1'b1;
            sum = sum + stream[2*w] + stream[2*w+1];
        end
        checkByte = badSum ? sum + 8'd1 : sum;
        if (CKSUM != 0 && badSum) expErr = 1'b1;

        leCount = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 0;
        idx      = 0;
        gapCnt   = 0;
        injected = 1'b0;

        while (idx < NBYTES && cyc < BUDGET) begin
            if (abortAfter > 0 && leCount >= abortAfter) break;
            case (gapMode)
                0:       in_valid = 1'b1;
                1:       in_valid = (gapCnt % 3 == 2);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            gapCnt++;
            in_data = (idx < 2*DEPTH) ? stream[idx] : checkByte;
            if (injectStart && !injected && idx == 5) begin
                start    = 1'b1;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            fire = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        start    = 1'b0;

        if (abortAfter > 0) begin
            checkOutput("abort_reached", (leCount >= abortAfter) ? 32'd1 : 32'd0, 32'd1);
            #2 rst = 1'b0;
            #1;
            checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd0);
            checkOutput("rst_LE", {31'h0, LE}, 32'd0);
            checkOutput("rst_LA", {24'h0, LA}, 32'd0);
            checkOutput("rst_LI", {20'h0, LI}, 32'd0);
            checkOutput("rst_load_done", {31'h0, load_done}, 32'd0);
            checkOutput("rst_busy", {31'h0, busy}, 32'd0);
            checkOutput("rst_err", {31'h0, err}, 32'd0);
            expQ.delete();
            leAtReset = leCount;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            repeat (6) @(negedge clk);
            checkOutput("no_LE_after_reset", leCount, leAtReset);
            checkOutput("idle_busy", {31'h0, busy}, 32'd0);
            return;
        end

        while (!load_done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("load_done", {31'h0, load_done}, 32'd1);
        if (checkCycles) checkOutput("done_latency", cyc, 3*DEPTH + CKSUM);
        checkOutput("done_err", {31'h0, err}, {31'h0, expErr});
        checkOutput("done_LA", {24'h0, LA}, DEPTH - 1);
        checkOutput("done_busy", {31'h0, busy}, 32'd0);
        checkOutput("done_in_ready", {31'h0, in_ready}, 32'd0);
        checkOutput("words_missing", expQ.size(), 32'd0);
        checkOutput("LE_count", leCount, DEPTH);
        repeat (3) @(negedge clk);
        checkOutput("done_hold", {31'h0, load_done}, 32'd1);
        checkOutput("done_hold_LA", {24'h0, LA}, DEPTH - 1);
    endtask

    // Test sequence: reset values, pattern loads (continuous, gapped, bad
    // nibble with a stray start), mid-load reset and reload, random loads.
    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", {31'h0, in_ready}, 32'd0);
        checkOutput("reset_LE", {31'h0, LE}, 32'd0);
        checkOutput("reset_LA", {24'h0, LA}, 32'd0);
        checkOutput("reset_LI", {20'h0, LI}, 32'd0);
        checkOutput("reset_load_done", {31'h0, load_done}, 32'd0);
        checkOutput("reset_busy", {31'h0, busy}, 32'd0);
        checkOutput("reset_err", {31'h0, err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] continuous pattern load");
        fillPattern();
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b1);

        $display("[TB] gapped pattern load");
        applyStimulus(1, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] bad high nibble on word 3 with stray start");
        fillPattern();
        stream[7] = 8'h5C;
        applyStimulus(0, 1'b1, 0, 1'b0, 1'b1);

        $display("[TB] reset after word 4, then reload");
        fillPattern();
        applyStimulus(0, 1'b0, 5, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b1);

`ifdef PMEM_LOADER_CHECKSUM_EN
        $display("[TB] wrong checksum byte");
        applyStimulus(0, 1'b0, 0, 1'b1, 1'b1);
`endif

        $display("[TB] random loads");
        for (int n = 0; n < 4; n++) begin
            fillRandom();
            applyStimulus(2, 1'b0, 0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
